prog_chain_loader: RTL and testbench
====================================

// Module: prog_chain_loader
// PURPOSE
//   Configuration controller for the prog_mux scan chain. Accepts config
//   words over a valid/ready stream, serializes them MSB-first onto the chain
//   (prog_data/prog_en) for exactly CHAIN_LEN bits, and repacks the bits
//   leaving the chain tail (old config) into readback words. One per fabric.
// PARAMETERS
//   CHAIN_LEN  64  total config bits in the chain (sum of all SEL); >= 1
//   WORD_W     8   bits per cfg/readback word; >= 2
// PORTS
//   prog_clk        in   1       single clock; chain shares it
//   rst             in   1       synchronous, active-high reset
//   start           in   1       begin a load; honoured only in IDLE
//   cfg_data        in   WORD_W  config word, MSB shifted first
//   cfg_valid       in   1       cfg_data valid
//   cfg_ready       out  1       controller accepts cfg_data this cycle
//   prog_data       out  1       to prog_in of the first chain stage
//   prog_en         out  1       chain shift enable
//   chain_out       in   1       prog_out of the last chain stage
//   busy            out  1       high in LOAD/SHIFT/DONE
//   done            out  1       1-cycle pulse, load complete
//   rb_data         out  WORD_W  readback word
//   rb_valid        out  1       1-cycle pulse, rb_data valid (no backpressure)
// BEHAVIOUR
//   Reset: state=IDLE; cfg_ready, prog_en, prog_data, busy, done, rb_valid=0;
//     rb_data=0; bit/word counters=0. Reset mid-load aborts at once; chain
//     holds a partial config (contents undefined, not touched further).
//   FSM: IDLE -start-> LOAD; LOAD -(cfg_valid&cfg_ready)-> SHIFT;
//     SHIFT -(word bits done, bits remain)-> LOAD; SHIFT -(total==CHAIN_LEN)->
//     DONE; DONE -> IDLE (unconditional, done=1 for that one cycle).
//   cfg_ready = 1 only in LOAD (Moore); word latched into shift reg on accept.
//   SHIFT: prog_en=1 every cycle; prog_data = shreg MSB; shreg shifts left.
//     Bits per word = WORD_W, except final word = CHAIN_LEN - WORD_W*(N-1),
//     N = ceil(CHAIN_LEN/WORD_W); unused final-word LSBs are discarded.
//   Readback: on each prog_en edge chain_out is sampled (old tail bit) and
//     shifted into rb shreg LSB. At end of each word rb_data = captured bits
//     left-justified (short final word: LSBs zero), rb_valid pulses next cycle.
//     Readback order equals load order of the previous config.
//   Timing (cfg_valid held high): start@0 -> LOAD@1, accept@1, SHIFT@2..9,
//     LOAD@10 ...; one bubble cycle per word. prog_en high exactly CHAIN_LEN
//     cycles per load. start during busy ignored; cfg_valid outside LOAD
//     ignored (not consumed). Stall in LOAD (cfg_valid=0) holds prog_en=0.
//   Counters: bit counter width $clog2(CHAIN_LEN+1); no wrap within a load.
// TESTING
//   1 CHAIN_LEN=64,WORD_W=8, 8 words 0x01..0x08 back-to-back -> prog_en high
//     64 cycles, done pulse at cycle 73, model chain equals stream MSB-first.
//   2 Load 0xA5 x8 then load 0x3C x8 -> second load rb_data = 0xA5 x8,
//     8 rb_valid pulses, each 1 cycle after word's last shift.
//   3 CHAIN_LEN=20,WORD_W=8, words 0xFF,0x00,0xF3 -> 20 prog_en cycles, last
//     word shifts only 1111; final rb_data has low 4 bits = 0.
//   4 Deassert cfg_valid 5 cycles before word 3 -> cfg_ready held, prog_en=0,
//     no state change; resumes, chain result identical to scenario 1.
//   5 start pulsed during SHIFT, cfg_valid high in IDLE -> ignored, no extra
//     load, cfg word not consumed (cfg_ready=0).
//   6 rst asserted at 30th shift cycle -> next cycle IDLE, all outputs 0,
//     prog_en=0; new start loads full 64 bits correctly.

Source files
------------

// File: rtl/prog_chain_loader.sv
// Scan-chain configuration loader: serializes cfg words MSB-first onto the
// prog chain for exactly CHAIN_LEN bits and repacks the displaced tail bits into readback words.
module prog_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_data,
    output logic              prog_en,
    input  logic              chain_out,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rb_shreg;
    logic [CW-1:0]     total;
    logic [WW-1:0]     wcnt;
    logic [WW-1:0]     cur_len;
    logic [31:0]       remain;
    logic              last_bit;
    logic [WORD_W-1:0] rb_word;

    assign remain    = 32'(LEN - total);
    assign last_bit  = (wcnt + WW'(1)) == cur_len;
    // Short final word: captured bits sit in the LSBs, so left-justify them.
    assign rb_word   = {rb_shreg[WORD_W-2:0], chain_out} << (WW'(WORD_W) - cur_len);
    assign prog_data = prog_en & shreg[WORD_W-1];

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b0;
            prog_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rb_valid  <= 1'b0;
            rb_data   <= '0;
            shreg     <= '0;
            rb_shreg  <= '0;
            total     <= '0;
            wcnt      <= '0;
            cur_len   <= '0;
        end else begin
            done     <= 1'b0;
            rb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        total     <= '0;
                    end
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        shreg     <= cfg_data;
                        rb_shreg  <= '0;
                        wcnt      <= '0;
                        cur_len   <= (remain >= 32'(WORD_W)) ? WW'(WORD_W) : WW'(remain);
                        cfg_ready <= 1'b0;
                        prog_en   <= 1'b1;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg    <= shreg << 1;
                    rb_shreg <= {rb_shreg[WORD_W-2:0], chain_out};
                    wcnt     <= wcnt + WW'(1);
                    total    <= total + CW'(1);
                    if (last_bit) begin
                        prog_en  <= 1'b0;
                        rb_data  <= rb_word;
                        rb_valid <= 1'b1;
                        if (total + CW'(1) == LEN) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: a 64-bit and a 20-bit instance, each driving a
// behavioural chain model; readback words are checked against a scoreboard.
module tb_prog_chain_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cfg_valid, chain_out;
    logic [7:0] cfg_data;
    logic       cfg_ready, prog_data, prog_en, busy, done, rb_valid;
    logic [7:0] rb_data;

    logic       b_start, b_cfg_valid, b_chain_out;
    logic [7:0] b_cfg_data;
    logic       b_cfg_ready, b_prog_data, b_prog_en, b_busy, b_done, b_rb_valid;
    logic [7:0] b_rb_data;

    int checks = 0;
    int passed = 0;

    logic [63:0] chain_a = 64'hDEADBEEF01234567;
    logic [19:0] chain_b = 20'hABCDE;
    assign chain_out   = chain_a[63];
    assign b_chain_out = chain_b[19];

    always @(posedge clk) begin
        if (prog_en)   chain_a <= {chain_a[62:0], prog_data};
        if (b_prog_en) chain_b <= {chain_b[18:0], b_prog_data};
    end

    prog_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut (
        .prog_clk(clk), .rst(rst), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .prog_data(prog_data),
        .prog_en(prog_en), .chain_out(chain_out), .busy(busy), .done(done),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    prog_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
        .prog_clk(clk), .rst(rst), .start(b_start), .cfg_data(b_cfg_data),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .prog_data(b_prog_data),
        .prog_en(b_prog_en), .chain_out(b_chain_out), .busy(b_busy), .done(b_done),
        .rb_data(b_rb_data), .rb_valid(b_rb_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Readback scoreboards: words pushed when a load is started, popped on rb_valid.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit prev_en_a = 1'b0;
    bit prev_en_b = 1'b0;

    always @(negedge clk) begin
        if (rb_valid) begin
            if (qa.size() == 0) begin
                checks++;
                $display("FAIL rb_a_extra: got %h expected no word", rb_data);
            end else begin
                check("rb_a_data", rb_data, qa.pop_front());
                check("rb_a_timing", {prev_en_a, prog_en}, 2'b10);
            end
        end
        if (b_rb_valid) begin
            if (qb.size() == 0) begin
                checks++;
                $display("FAIL rb_b_extra: got %h expected no word", b_rb_data);
            end else begin
                check("rb_b_data", b_rb_data, qb.pop_front());
                check("rb_b_timing", {prev_en_b, b_prog_en}, 2'b10);
            end
        end
        prev_en_a = prog_en;
        prev_en_b = b_prog_en;
    end

    // Cycle 0 is the start cycle; returns at the negedge of the done cycle,
    // or of the abort_at-th shift cycle with rst raised.
    task automatic load_a(input logic [63:0] w, input int gap_word, input int gap_len,
                          input bit poke, input int abort_at,
                          output int done_cyc, output int en_cnt);
        int idx, stall;
        bit acc, stall_bad;
        logic [63:0] t;
        idx = 0; stall = 0; done_cyc = -1; en_cnt = 0; stall_bad = 0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_data = w[63:56];
        cfg_valid = !(gap_word == 0 && gap_len > 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (prog_en) en_cnt++;
            if (done) done_cyc = cyc;
            if (idx == gap_word && cfg_ready && !cfg_valid) begin
                stall++;
                if (prog_en || !busy) stall_bad = 1'b1;
            end
            acc = cfg_ready && cfg_valid;
            if (abort_at > 0 && en_cnt == abort_at) begin
                rst = 1'b1;
                break;
            end
            if (done_cyc >= 0) break;
            @(posedge clk); #1;
            start = poke && cyc == 4;
            if (acc) idx++;
            t = w << (8 * idx);
            cfg_data = t[63:56];
            cfg_valid = (idx < 8) && !(idx == gap_word && stall < gap_len);
        end
        start = 1'b0;
        if (gap_len > 0) check("stall_hold", {63'd0, stall_bad}, 64'd0);
    endtask

    task automatic load_b(input logic [23:0] w, output int done_cyc, output int en_cnt);
        int idx;
        bit acc;
        logic [23:0] t;
        idx = 0; done_cyc = -1; en_cnt = 0;
        @(posedge clk); #1;
        b_start = 1'b1; b_cfg_valid = 1'b1; b_cfg_data = w[23:16];
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (b_prog_en) en_cnt++;
            if (b_done) done_cyc = cyc;
            acc = b_cfg_ready && b_cfg_valid;
            if (done_cyc >= 0) break;
            @(posedge clk); #1;
            b_start = 1'b0;
            if (acc) idx++;
            t = w << (8 * idx);
            b_cfg_data = t[23:16];
            b_cfg_valid = idx < 3;
        end
        b_start = 1'b0;
        b_cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] words;
        int          gap_word;
        int          gap_len;
        bit          poke;
        int          exp_done;
    } vec_t;

    vec_t tv[5];
    logic [63:0] prev, s_word, partial;
    int dc, ec;
    bit bad;

    initial begin
        tv[0] = '{64'h0102030405060708, -1, 0, 1'b0, 73};
        tv[1] = '{64'hA5A5A5A5A5A5A5A5, -1, 0, 1'b0, 73};
        tv[2] = '{64'h3C3C3C3C3C3C3C3C, -1, 0, 1'b0, 73};
        tv[3] = '{64'h0102030405060708,  3, 5, 1'b0, 78};
        tv[4] = '{64'h0102030405060708, -1, 0, 1'b1, 73};
        prev = 64'hDEADBEEF01234567;

        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        b_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {cfg_ready, prog_en, prog_data, busy, done, rb_valid, rb_data}, 64'd0);
        check("reset_b", {b_cfg_ready, b_prog_en, b_prog_data, b_busy, b_done, b_rb_valid, b_rb_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) qa.push_back(prev[63-8*k -: 8]);
            load_a(tv[i].words, tv[i].gap_word, tv[i].gap_len, tv[i].poke, 0, dc, ec);
            check($sformatf("v%0d_done_cycle", i), dc, tv[i].exp_done);
            check($sformatf("v%0d_busy_in_done", i), {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_prog_en_cycles", i), ec, 64);
            check($sformatf("v%0d_chain", i), chain_a, tv[i].words);
            check($sformatf("v%0d_idle_after", i), {done, busy, prog_en}, 64'd0);
            check($sformatf("v%0d_rb_count", i), qa.size(), 0);
            prev = tv[i].words;
        end

        // cfg_valid in IDLE must not start anything or be consumed
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_data = 8'h11;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cfg_ready || prog_en || busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("idle_cfg_ignored", {63'd0, bad}, 64'd0);

        // Reset during the 30th shift cycle: 30 bits of the new stream are in the chain
        s_word = 64'h1122334455667788;
        for (int k = 0; k < 3; k++) qa.push_back(prev[63-8*k -: 8]);
        load_a(s_word, -1, 0, 1'b0, 30, dc, ec);
        check("abort_shift_count", ec, 30);
        @(negedge clk);
        check("abort_outputs", {cfg_ready, prog_en, prog_data, busy, done, rb_valid, rb_data}, 64'd0);
        partial = {prev[33:0], s_word[63:34]};
        check("abort_chain", chain_a, partial);
        check("abort_rb_count", qa.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 8; k++) qa.push_back(partial[63-8*k -: 8]);
        load_a(s_word, -1, 0, 1'b0, 0, dc, ec);
        check("reload_done_cycle", dc, 73);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("reload_prog_en_cycles", ec, 64);
        check("reload_chain", chain_a, s_word);
        check("reload_rb_count", qa.size(), 0);

        // Short final word on the 20-bit chain
        qb.push_back(8'hAB); qb.push_back(8'hCD); qb.push_back(8'hE0);
        load_b(24'hFF00F3, dc, ec);
        check("b1_done_cycle", dc, 24);
        @(negedge clk);
        check("b1_prog_en_cycles", ec, 20);
        check("b1_chain", chain_b, 20'hFF00F);
        qb.push_back(8'hFF); qb.push_back(8'h00); qb.push_back(8'hF0);
        load_b(24'h3C5A81, dc, ec);
        check("b2_done_cycle", dc, 24);
        @(negedge clk);
        check("b2_prog_en_cycles", ec, 20);
        check("b2_chain", chain_b, 20'h3C5A8);
        check("b_rb_count", qb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
